flb_dwa: RTL
============

# flb_dwa

Data-weighted-averaging (DWA) element selector for the FLB offset DAC. Sits directly downstream of the sigma-delta modulator and consumes its 2-bit binary or 3-bit thermometer output. Each cycle it enables that many unit elements, chosen by rotating a pointer around the element ring so that element-mismatch error is first-order shaped. It also keeps per-element saturating usage counters and a sticky illegal-code flag for CSR readback.

## Interface
- NUM_EL, 3, number of unit DAC elements; must be >= 3.
- CNT_W, 16, width of each per-element usage counter.
- PTR_W, $clog2(NUM_EL), pointer width; derived, not overridden.
- nsh_clk  in  1  block clock, same domain as the modulator.
- nsh_rst  in  1  reset, asynchronous, active-high.
- csr_flb_dwa_en  in  1  1 = rotate; 0 = static pass-through, pointer held at 0.
- csr_flb_sdm_thrm_en  in  1  source select: 1 = use os_thrm, 0 = use os_bin.
- csr_flb_dwa_clr  in  1  synchronous clear of usage counters and error flag.
- os_bin  in  2  modulator binary level, 0..3.
- os_thrm  in  3  modulator thermometer code.
- el_sel  out  NUM_EL  registered unit-element enables.
- dwa_ptr  out  PTR_W  current rotation pointer.
- dwa_err  out  1  sticky flag for an illegal thermometer code.
- cnt_el  out  NUM_EL*CNT_W  usage counters; element i is at bits [i*CNT_W +: CNT_W].

## Operation
- Level k is computed each cycle.
  - When csr_flb_sdm_thrm_en=1: k = popcount(os_thrm).
  - When csr_flb_sdm_thrm_en=0: k = os_bin.
  - k is clipped to NUM_EL.
- Legal thermometer codes are 000, 001, 011 and 111.
  - Any other os_thrm with csr_flb_sdm_thrm_en=1 sets dwa_err.
  - k is still popcount.
- Rotate mode (csr_flb_dwa_en=1):
  - el_sel next = k consecutive ones starting at bit ptr, wrapping from bit NUM_EL-1 to bit 0.
  - ptr next = (ptr + k) mod NUM_EL, computed in PTR_W+1 bits, then one conditional subtract.
  - k=0: el_sel=0, ptr unchanged.
  - k=NUM_EL: all ones, ptr unchanged.
- Pass-through mode (csr_flb_dwa_en=0):
  - el_sel next = low k bits set.
  - ptr forced to 0 on that edge.
  - Re-enabling rotation starts from ptr=0.
- Usage counters:
  - Counter i increments on each edge where registered el_sel[i]=1.
  - Counters saturate at all-ones and never wrap.
- csr_flb_dwa_clr:
  - Zeroes all counters and dwa_err on the next edge.
  - Takes priority over a simultaneous increment or error set.
- Reset values: el_sel=0, dwa_ptr=0, dwa_err=0, cnt_el=0.

## Timing
- Inputs are sampled on the rising edge of nsh_clk. el_sel, dwa_ptr and dwa_err update on that edge, a latency of 1 cycle.
- Counters reflect el_sel one cycle after it appears, a latency of 2 cycles from the input.
- Reset asserted mid-operation clears everything immediately, with no clock required. The first active edge after deassertion processes the current input with ptr=0.
- Mode or source-select changes take effect on the next edge. There is no flush cycle.
- No handshake: one level is consumed per cycle, and the modulator is assumed to produce one per cycle.

## Structure
- Shared package flb_pkg holds:
  - FLB_NUM_EL default and FLB_CNT_W default;
  - function thrm_legal(logic [2:0]) returning 1 for the legal codes;
  - function popcount3.
- Sub-module flb_sat_cnt: CNT_W-bit saturating counter with inc and synchronous clr, clr dominant. It is instantiated NUM_EL times via generate.
- The rotation mask is built as (2^k − 1) rotated left by ptr on a 2*NUM_EL-bit doubled vector, then folded.

## Test plan
- Rotation sequence (NUM_EL=3, en=1, thrm mode), input os_thrm 011, 011, 001, 111:
  - el_sel = 011, 101, 010, 111;
  - ptr = 2, 1, 2, 2.
- Binary source (thrm_en=0), os_bin 2, 2, 2, 2 from reset:
  - el_sel = 011, 101, 110, 011;
  - each element is selected exactly twice per 3 cycles on average;
  - ptr cycles 2, 1, 0, 2.
- Pass-through (en=0), os_bin = 1, 2, 3, 0:
  - el_sel = 001, 011, 111, 000;
  - dwa_ptr stays 0.
- Illegal code:
  - os_thrm=010 in thrm mode gives dwa_err=1 after one edge and el_sel uses k=1;
  - dwa_err stays set after legal codes;
  - clr asserted for one cycle → dwa_err=0 and cnt_el=0.
- Counter saturation (CNT_W=4, k=3 held for 20 cycles):
  - every counter stops at 15;
  - clr asserted together with an active el_sel leaves the counters at 0.
- Async reset mid-stream:
  - assert nsh_rst while ptr=2 → outputs 0 immediately, without a clock edge;
  - after release, os_thrm=001 → el_sel=001 and ptr=1.

Source files
------------

// File: rtl/flb_pkg.sv
// Shared FLB definitions: default DWA sizing and thermometer-code helpers.
package flb_pkg;

    localparam int unsigned FLB_NUM_EL = 3;
    localparam int unsigned FLB_CNT_W  = 16;

    // 1 for the monotone thermometer codes 000, 001, 011, 111.
    function automatic logic thrm_legal(input logic [2:0] code);
        logic ok;
        case (code)
            3'b000, 3'b001, 3'b011, 3'b111: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Number of set bits in a 3-bit code.
    function automatic logic [1:0] popcount3(input logic [2:0] code);
        return 2'(code[0]) + 2'(code[1]) + 2'(code[2]);
    endfunction

endpackage

// File: rtl/flb_dwa_if.sv
// Modulator-to-DWA data path bundle.
//   os_bin/os_thrm : modulator level (driven by master)
//   el_sel/dwa_ptr/dwa_err/cnt_el : selector results (driven by slave)
interface flb_dwa_if #(
    parameter int unsigned NUM_EL = 3,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned PTR_W = $clog2(NUM_EL);

    logic [1:0]              os_bin;
    logic [2:0]              os_thrm;
    logic [NUM_EL-1:0]       el_sel;
    logic [PTR_W-1:0]        dwa_ptr;
    logic                    dwa_err;
    logic [NUM_EL*CNT_W-1:0] cnt_el;

    modport master (
        output os_bin, os_thrm,
        input  el_sel, dwa_ptr, dwa_err, cnt_el
    );

    modport slave (
        input  os_bin, os_thrm,
        output el_sel, dwa_ptr, dwa_err, cnt_el
    );
endinterface

// File: rtl/flb_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//   nsh_clk/nsh_rst : clock, async active-high reset
//   inc, clr        : count enable, synchronous clear
//   cnt             : current count, sticks at all-ones
module flb_sat_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             nsh_clk,
    input  logic             nsh_rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge nsh_clk or posedge nsh_rst) begin
        if (nsh_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/flb_dwa.sv
// Data-weighted-averaging element selector for the FLB offset DAC.
//   nsh_clk/nsh_rst     : clock, async active-high reset
//   csr_flb_dwa_en      : 1 = rotate pointer, 0 = static low-k pass-through
//   csr_flb_sdm_thrm_en : 1 = level from os_thrm popcount, 0 = from os_bin
//   csr_flb_dwa_clr     : synchronous clear of usage counters and dwa_err
//   bus                 : modulator level in, element enables/pointer/flags out
module flb_dwa
    import flb_pkg::*;
#(
    parameter int unsigned NUM_EL = FLB_NUM_EL,
    parameter int unsigned CNT_W  = FLB_CNT_W
) (
    input  logic        nsh_clk,
    input  logic        nsh_rst,
    input  logic        csr_flb_dwa_en,
    input  logic        csr_flb_sdm_thrm_en,
    input  logic        csr_flb_dwa_clr,
    flb_dwa_if.slave    bus
);

    localparam int unsigned PTR_W = $clog2(NUM_EL);
    localparam int unsigned KW    = PTR_W + 1;
    localparam int unsigned DW    = 2 * NUM_EL;

    logic [NUM_EL-1:0]       el_sel_q,  el_sel_nxt;
    logic [PTR_W-1:0]        ptr_q,     ptr_nxt;
    logic                    err_q,     err_nxt;
    logic [NUM_EL*CNT_W-1:0] cnt_flat;

    logic [KW-1:0] k_raw_c, k_c, sum_c, sum_wrap_c;
    logic [DW-1:0] base_c, dbl_c;
    logic [NUM_EL-1:0] rot_c;

    // Level select, mask generation and pointer advance.
    always_comb begin
        k_raw_c    = '0;
        k_c        = '0;
        base_c     = '0;
        dbl_c      = '0;
        rot_c      = '0;
        sum_c      = '0;
        sum_wrap_c = '0;
        el_sel_nxt = '0;
        ptr_nxt    = '0;
        err_nxt    = err_q;

        k_raw_c = csr_flb_sdm_thrm_en ? KW'(popcount3(bus.os_thrm)) : KW'(bus.os_bin);
        k_c     = (32'(k_raw_c) > NUM_EL) ? KW'(NUM_EL) : k_raw_c;

        // k ones rotated by ptr on a doubled ring, upper half folded onto lower.
        base_c = (DW'(1) << k_c) - DW'(1);
        dbl_c  = base_c << ptr_q;
        rot_c  = dbl_c[NUM_EL-1:0] | dbl_c[DW-1:NUM_EL];

        // ptr + k never reaches 2*NUM_EL, so one subtract suffices.
        sum_c      = KW'(ptr_q) + k_c;
        sum_wrap_c = (32'(sum_c) >= NUM_EL) ? (sum_c - KW'(NUM_EL)) : sum_c;

        if (csr_flb_dwa_en) begin
            el_sel_nxt = rot_c;
            ptr_nxt    = PTR_W'(sum_wrap_c);
        end else begin
            el_sel_nxt = base_c[NUM_EL-1:0];
            ptr_nxt    = '0;
        end

        if (csr_flb_dwa_clr) begin
            err_nxt = 1'b0;
        end else if (csr_flb_sdm_thrm_en && !thrm_legal(bus.os_thrm)) begin
            err_nxt = 1'b1;
        end
    end

    // Selector state.
    always_ff @(posedge nsh_clk or posedge nsh_rst) begin
        if (nsh_rst) begin
            el_sel_q <= '0;
            ptr_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            el_sel_q <= el_sel_nxt;
            ptr_q    <= ptr_nxt;
            err_q    <= err_nxt;
        end
    end

    // One usage counter per element, fed by the registered enables.
    for (genvar i = 0; i < NUM_EL; i++) begin : g_cnt
        flb_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
            .nsh_clk (nsh_clk),
            .nsh_rst (nsh_rst),
            .inc     (el_sel_q[i]),
            .clr     (csr_flb_dwa_clr),
            .cnt     (cnt_flat[i*CNT_W +: CNT_W])
        );
    end

    assign bus.el_sel  = el_sel_q;
    assign bus.dwa_ptr = ptr_q;
    assign bus.dwa_err = err_q;
    assign bus.cnt_el  = cnt_flat;

endmodule
